// File: rtl/conv2_pkg.sv
// Shared types and constants for the 3x3 conv sequencer.
package conv2_pkg;

    localparam int ACC_W   = 18;
    localparam int TAPS    = 9;
    localparam int SEL_MAX = 2;
    localparam int CNT_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MAC,
        CAPT,
        OUT,
        LOAD,
        DONE
    } state_t;

    // Column rotation 0 -> 1 -> 2 -> 0; the value 3 is never produced.
    function automatic logic [1:0] sel_next(input logic [1:0] s);
        if (s >= 2'(SEL_MAX)) begin
            return 2'd0;
        end
        return s + 2'd1;
    endfunction

endpackage

// File: rtl/conv2_tap_cnt.sv
// Tap index counter 0..TAPS-1 for the MAC phase, with a last-tap flag.
// Wraps to 0 after the last tap so every MAC phase starts at tap 0.
module conv2_tap_cnt #(
    parameter int TAPS  = conv2_pkg::TAPS,
    parameter int CNT_W = conv2_pkg::CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Advance while enabled, wrapping after the last tap.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (cnt_q == CNT_W'(TAPS - 1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CNT_W'(TAPS - 1));

endmodule

// File: rtl/conv2_seq_ctrl.sv
// Sequencer for the 3x3 conv MAC datapath: clear, 9 MAC taps, capture,
// valid/ready hand-off, then column load with sel rotation between pixels.
// Optional macro CONV2_RELU_EN: clamp negative captured sums to zero.
// All outputs are decoded from registered state; no input-to-output paths.
module conv2_seq_ctrl #(
    parameter int N_OUT = 8,
    parameter int ACC_W = conv2_pkg::ACC_W,
    parameter int TAPS  = conv2_pkg::TAPS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [ACC_W-1:0] acc_i,
    output logic [1:0]       sel_o,
    output logic [3:0]       counter_o,
    output logic             and_control_o,
    output logic             we_o,
    output logic             acc_rst_n_o,
    output logic             col_load_o,
    input  logic             col_ready_i,
    output logic [ACC_W-1:0] res_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             busy_o,
    output logic             done_o
);
    import conv2_pkg::*;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [7:0]       idx_q, idx_d;
    logic [ACC_W-1:0] res_q, res_d;
    logic [ACC_W-1:0] capt_val;
    logic             tap_last;
    logic             tap_en;

    assign tap_en = (state_q == MAC);

    conv2_tap_cnt #(
        .TAPS  (TAPS),
        .CNT_W (4)
    ) u_tap_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (tap_en),
        .cnt_o  (counter_o),
        .last_o (tap_last)
    );

    // Value latched in CAPT: optionally rectified sum.
    always_comb begin
        capt_val = acc_i;
`ifdef CONV2_RELU_EN
        if (acc_i[ACC_W-1]) begin
            capt_val = '0;
        end
`endif
    end

    // Next-state, pixel index, column select and result capture.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CLEAR;
                    sel_d   = 2'd0;
                    idx_d   = 8'd0;
                end
            end
            CLEAR: state_d = MAC;
            MAC: begin
                if (tap_last) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                res_d   = capt_val;
                state_d = OUT;
            end
            OUT: begin
                if (res_ready_i) begin
                    if (idx_q == 8'(N_OUT - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (col_ready_i) begin
                    sel_d   = sel_next(sel_q);
                    idx_d   = idx_q + 8'd1;
                    state_d = CLEAR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath-control registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            idx_q   <= 8'd0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
        end
    end

    assign sel_o         = sel_q;
    assign res_o         = res_q;
    assign and_control_o = (state_q == MAC);
    assign we_o          = (state_q == MAC);
    assign acc_rst_n_o   = (state_q != CLEAR);
    assign col_load_o    = (state_q == LOAD);
    assign res_valid_o   = (state_q == OUT);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);

endmodule
